// File: rtl/instr_fetch_pkg.sv
// Shared CPU definitions: fetch FSM encodings, debounce default and opcode map.
package instr_fetch_pkg;

  localparam int DEBOUNCE_CYCLES_DEF = 16;

  typedef enum logic [1:0] {
    WAIT_HI = 2'd0,
    WAIT_LO = 2'd1,
    ISSUE   = 2'd2,
    EXEC    = 2'd3
  } fetch_state_e;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDI  = 4'h1,
    OP_ADD  = 4'h2,
    OP_SUB  = 4'h3,
    OP_AND  = 4'h4,
    OP_OR   = 4'h5,
    OP_XOR  = 4'h6,
    OP_JMP  = 4'h7,
    OP_JZ   = 4'h8,
    OP_OUT  = 4'h9,
    OP_HALT = 4'hF
  } opcode_e;

  // Replace the low byte of a staged instruction word.
  function automatic logic [15:0] merge_low(input logic [15:0] stage, input logic [7:0] lo);
    return {stage[15:8], lo};
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, counter debounce, rising-edge pulse.
module btn_debounce
  import instr_fetch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic rise_pulse
);

  localparam logic [7:0] LAST_CNT = 8'(DEBOUNCE_CYCLES - 1);

  logic       sync1_r;
  logic       sync2_r;
  logic       level_r;
  logic       level_q_r;
  logic       rise_r;
  logic [7:0] cnt_r;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= btn_raw;
      sync2_r <= sync1_r;
    end
  end

  // Level flips only after DEBOUNCE_CYCLES uninterrupted disagreeing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_r <= 1'b0;
      cnt_r   <= 8'd0;
    end else if (sync2_r != level_r) begin
      if (cnt_r == LAST_CNT) begin
        level_r <= sync2_r;
        cnt_r   <= 8'd0;
      end else begin
        cnt_r   <= cnt_r + 8'd1;
      end
    end else begin
      cnt_r <= 8'd0;
    end
  end

  // One-cycle pulse the cycle after the debounced level rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q_r <= 1'b0;
      rise_r    <= 1'b0;
    end else begin
      level_q_r <= level_r;
      rise_r    <= level_r & ~level_q_r;
    end
  end

  assign level      = level_r;
  assign rise_pulse = rise_r;

endmodule

// File: rtl/instr_fetch.sv
// Two-press instruction entry: high byte, low byte, then issue to the core and wait for it.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  sw_in,
  input  logic        btn_raw,
  input  logic        core_busy,
  output logic [3:0]  opcode,
  output logic [11:0] instr,
  output logic        inst_done,
  output logic        btn_edge,
  output logic [1:0]  state_dbg
);

  fetch_state_e state_r;
  logic [15:0]  staging_r;
  logic [3:0]   opcode_r;
  logic [11:0]  instr_r;
  logic         inst_done_r;
  logic         exec_min_r;
  logic         btn_edge_s;
  logic         btn_level_s;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn_raw),
    .level     (btn_level_s),
    .rise_pulse(btn_edge_s)
  );

  // Fetch FSM; outputs are loaded on the edge into ISSUE so they are valid while inst_done is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= WAIT_HI;
      staging_r   <= 16'd0;
      opcode_r    <= 4'd0;
      instr_r     <= 12'd0;
      inst_done_r <= 1'b0;
      exec_min_r  <= 1'b0;
    end else begin
      inst_done_r <= 1'b0;
      case (state_r)
        WAIT_HI: begin
          if (btn_edge_s) begin
            staging_r[15:8] <= sw_in;
            state_r         <= WAIT_LO;
          end
        end
        WAIT_LO: begin
          if (btn_edge_s) begin
            staging_r             <= merge_low(staging_r, sw_in);
            {opcode_r, instr_r}   <= merge_low(staging_r, sw_in);
            inst_done_r           <= 1'b1;
            state_r               <= ISSUE;
          end
        end
        ISSUE: begin
          exec_min_r <= 1'b0;
          state_r    <= EXEC;
        end
        EXEC: begin
          // First EXEC cycle only arms the minimum; core_busy is honoured from the second on.
          if (exec_min_r && !core_busy) begin
            state_r <= WAIT_HI;
          end else begin
            exec_min_r <= 1'b1;
          end
        end
        default: state_r <= WAIT_HI;
      endcase
    end
  end

  assign opcode    = opcode_r;
  assign instr     = instr_r;
  assign inst_done = inst_done_r;
  assign btn_edge  = btn_edge_s;
  assign state_dbg = state_r;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch with DEBOUNCE_CYCLES=4.
module tb_instr_fetch;

  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  sw_in = 8'h00;
  logic        btn_raw = 1'b0;
  logic        core_busy = 1'b0;
  logic [3:0]  opcode;
  logic [11:0] instr;
  logic        inst_done;
  logic        btn_edge;
  logic [1:0]  state_dbg;

  instr_fetch #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk      (clk),
    .rst      (rst),
    .sw_in    (sw_in),
    .btn_raw  (btn_raw),
    .core_busy(core_busy),
    .opcode   (opcode),
    .instr    (instr),
    .inst_done(inst_done),
    .btn_edge (btn_edge),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0;
  int nerr = 0;
  logic [15:0] exp_instr_q[$];
  int          exp_edge_q[$];
  logic        prev_done = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Clean press: edge expected 2 sync + DB debounce + 1 pulse cycles after the rise.
  task automatic press(input logic [7:0] b);
    sw_in   = b;
    btn_raw = 1'b1;
    exp_edge_q.push_back(cyc + DB + 3);
    wait_cycles(10);
    btn_raw = 1'b0;
    sw_in   = 8'($urandom);
    wait_cycles(10);
  endtask

  // Monitor: compare every btn_edge and inst_done against the scoreboard queues.
  always @(negedge clk) begin
    int e;
    logic [15:0] w;
    if (!rst) begin
      if (btn_edge) begin
        if (exp_edge_q.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL unexpected_btn_edge: got pulse at cycle %0d expected none", cyc);
        end else begin
          e = exp_edge_q.pop_front();
          check("btn_edge_cycle", cyc, e);
        end
      end
      if (inst_done) begin
        check("inst_done_single", int'(prev_done), 0);
        if (exp_instr_q.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL unexpected_inst_done: got 0x%0h expected none", {opcode, instr});
        end else begin
          w = exp_instr_q.pop_front();
          check("opcode", int'(opcode), int'(w[15:12]));
          check("instr", int'(instr), int'(w[11:0]));
        end
      end
    end
    prev_done <= inst_done;
  end

  initial begin
    // Reset state
    wait_cycles(2);
    check("rst_state", int'(state_dbg), 0);
    check("rst_opcode", int'(opcode), 0);
    check("rst_instr", int'(instr), 0);
    check("rst_inst_done", int'(inst_done), 0);
    check("rst_btn_edge", int'(btn_edge), 0);
    rst = 1'b0;
    wait_cycles(2);

    // Two clean presses build 0xA53C
    exp_instr_q.push_back(16'hA53C);
    press(8'hA5);
    check("state_after_hi", int'(state_dbg), 1);
    press(8'h3C);
    check("state_idle_a", int'(state_dbg), 0);
    check("hold_opcode_a", int'(opcode), 4'hA);
    check("hold_instr_a", int'(instr), 12'h53C);

    // Bouncy press captures 0x5F, a 3-cycle glitch is ignored, then 0x0F
    exp_instr_q.push_back(16'h5F0F);
    sw_in = 8'h5F;
    btn_raw = 1'b1; wait_cycles(1);
    btn_raw = 1'b0; wait_cycles(1);
    btn_raw = 1'b1; wait_cycles(1);
    btn_raw = 1'b0; wait_cycles(1);
    btn_raw = 1'b1;
    exp_edge_q.push_back(cyc + DB + 3);
    wait_cycles(10);
    btn_raw = 1'b0;
    sw_in = 8'hC7;
    wait_cycles(10);
    check("state_after_bounce", int'(state_dbg), 1);
    btn_raw = 1'b1; wait_cycles(3);
    btn_raw = 1'b0; wait_cycles(10);
    check("state_after_glitch", int'(state_dbg), 1);
    press(8'h0F);
    check("state_idle_b", int'(state_dbg), 0);

    // Core busy across EXEC; a press during EXEC must not capture
    exp_instr_q.push_back(16'hC321);
    press(8'hC3);
    core_busy = 1'b1;
    press(8'h21);
    check("state_exec_busy", int'(state_dbg), 3);
    sw_in = 8'hEE;
    btn_raw = 1'b1;
    exp_edge_q.push_back(cyc + DB + 3);
    for (int i = 0; i < 10; i++) begin
      wait_cycles(1);
      check("state_hold_exec", int'(state_dbg), 3);
    end
    core_busy = 1'b0;
    wait_cycles(1);
    check("state_exec_exit", int'(state_dbg), 0);
    btn_raw = 1'b0;
    wait_cycles(10);
    check("state_after_drop", int'(state_dbg), 0);
    check("hold_opcode_c", int'(opcode), 4'hC);
    check("hold_instr_c", int'(instr), 12'h321);

    // Reset mid-entry discards the 0xFF high byte
    press(8'hFF);
    check("state_ff_captured", int'(state_dbg), 1);
    rst = 1'b1;
    wait_cycles(1);
    check("midrst_state", int'(state_dbg), 0);
    check("midrst_opcode", int'(opcode), 0);
    check("midrst_instr", int'(instr), 0);
    rst = 1'b0;
    wait_cycles(1);
    exp_instr_q.push_back(16'h1234);
    press(8'h12);
    press(8'h34);
    check("final_opcode", int'(opcode), 4'h1);
    check("final_instr", int'(instr), 12'h234);

    // Button held high through reset release pulses once after the debounce latency
    btn_raw = 1'b1;
    rst = 1'b1;
    wait_cycles(2);
    rst = 1'b0;
    exp_edge_q.push_back(cyc + DB + 3);
    wait_cycles(12);
    check("state_after_held_rst", int'(state_dbg), 1);
    btn_raw = 1'b0;
    wait_cycles(10);

    check("pending_edges", exp_edge_q.size(), 0);
    check("pending_instr", exp_instr_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The module SHALL expose parameter DEBOUNCE_CYCLES, default 16, the number of consecutive disagreeing cycles needed before the debounced button level changes (legal range 2..255).
REQ-002 Port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 Port sw_in, input, 8 bits: raw switch byte, sampled only on an accepted press.
REQ-005 Port btn_raw, input, 1 bit: raw, asynchronous, bouncing push-button.
REQ-006 Port core_busy, input, 1 bit: high while cpu_core executes an instruction.
REQ-007 Port opcode, output, 4 bits: bits [15:12] of the assembled instruction.
REQ-008 Port instr, output, 12 bits: bits [11:0] of the assembled instruction.
REQ-009 Port inst_done, output, 1 bit: one-cycle pulse meaning opcode/instr hold a new complete instruction.
REQ-010 Port btn_edge, output, 1 bit: one-cycle pulse on each rising edge of the debounced button.
REQ-011 Port state_dbg, output, 2 bits: current FSM state encoding.

Function
REQ-012 btn_raw SHALL pass through a 2-flop synchronizer before any other use.
REQ-013 Debounce: while the synchronized level differs from the debounced level, a counter SHALL increment each cycle; it SHALL clear on any agreeing cycle.
REQ-014 The debounced level SHALL take the synchronized value, and the counter SHALL clear, on the DEBOUNCE_CYCLES-th consecutive disagreeing cycle.
REQ-015 btn_edge SHALL pulse for exactly one cycle, in the cycle after the debounced level goes 0->1, in every FSM state.
REQ-016 btn_edge latency SHALL be exactly 2+DEBOUNCE_CYCLES+1 cycles from a clean btn_raw rise.
REQ-017 Releases and glitches shorter than DEBOUNCE_CYCLES SHALL produce no pulse.
REQ-018 The FSM SHALL have four states: WAIT_HI=0, WAIT_LO=1, ISSUE=2, EXEC=3.
REQ-019 WAIT_HI: on btn_edge, sw_in SHALL be captured into instruction bits [15:8], and the FSM SHALL go to WAIT_LO.
REQ-020 WAIT_LO: on btn_edge, sw_in SHALL be captured into bits [7:0], and the FSM SHALL go to ISSUE.
REQ-021 opcode/instr SHALL update only in ISSUE, from the 16-bit staging register, and SHALL hold their value otherwise.
REQ-022 In ISSUE, inst_done SHALL be 1 for that single cycle, and the FSM SHALL then go to EXEC unconditionally.
REQ-023 EXEC SHALL last at least 2 cycles, then SHALL return to WAIT_HI in the first cycle in which core_busy is sampled 0.
REQ-024 A btn_edge in ISSUE or EXEC SHALL be dropped for capture: the staging register is unchanged and the FSM is unaffected.
REQ-025 sw_in changes outside a capture cycle SHALL have no effect.
REQ-026 inst_done SHALL never assert in two consecutive cycles.

Reset
REQ-027 rst SHALL asynchronously force FSM=WAIT_HI, opcode=0, instr=0, staging=0, inst_done=0, btn_edge=0, debounced level=0, debounce counter=0, synchronizer flops=0.
REQ-028 Reset mid-entry (in WAIT_LO) SHALL discard the captured high byte.
REQ-029 After rst deasserts with btn_raw held high, btn_edge SHALL pulse once after the debounce latency.

Structure
REQ-030 State encodings and the default DEBOUNCE_CYCLES value SHALL live in the shared CPU package, alongside the opcode definitions.
REQ-031 The synchronizer, debounce and edge logic SHALL be one sub-module, btn_debounce, with outputs level and rise_pulse.

Verification (DEBOUNCE_CYCLES=4)
REQ-032 Clean press, btn_raw 0->1 held -> btn_edge pulses once, exactly 7 cycles later.
REQ-033 Bounce 1,0,1,0 one cycle each, then held 1 -> exactly one btn_edge; a 3-cycle glitch -> none.
REQ-034 sw_in=0xA5 press, sw_in=0x3C press -> inst_done single pulse, opcode=0xA, instr=0x53C.
REQ-035 core_busy held 1 for 10 cycles after inst_done, third press meanwhile -> press ignored, FSM leaves EXEC only on the first core_busy=0 sample.
REQ-036 rst asserted in WAIT_LO after a 0xFF capture, then 0x12 and 0x34 entered -> opcode=0x1, instr=0x234.
